// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : Arbitrates ALU/load results into a FIFO and drains them to the
//            register file with a one-cycle write strobe and a recovery cycle.
// Revision : 1.0
// ============================================================================
module writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [2:0]                 alu_rd,
    input  logic [15:0]                alu_result,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [2:0]                 mem_rd,
    input  logic [15:0]                mem_data,
    output logic                       mem_ready,
    output logic [2:0]                 RW,
    output logic [15:0]                BusW,
    output logic                       sig_enable_write,
    output logic [7:0]                 pending_mask,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_run;
    logic          r_wr_en;
    logic [2:0]    r_rw;
    logic [15:0]   r_busw;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [2:0]    r_rd   [DEPTH];
    logic [15:0]   r_data [DEPTH];

    logic          w_not_full;
    logic          w_take_mem;
    logic          w_take_alu;
    logic [2:0]    w_in_rd;
    logic [15:0]   w_in_data;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_mask;

    // r_run keeps both readies low until the first edge after reset release
    assign w_not_full = r_run && (r_count < C_DEPTH);
    assign mem_ready  = w_not_full;
    assign alu_ready  = w_not_full && !mem_valid;

    assign w_take_mem = mem_valid && mem_ready;
    assign w_take_alu = alu_valid && alu_ready;
    assign w_in_rd    = w_take_mem ? mem_rd   : alu_rd;
    assign w_in_data  = w_take_mem ? mem_data : alu_result;
    assign w_push     = (w_take_mem || w_take_alu) && (w_in_rd != 3'd0);
    assign w_pop      = ((r_state == S_IDLE) || (r_state == S_RECOVER)) && (r_count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run    <= 1'b0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rd[r_wr_ptr]   <= w_in_rd;
            r_data[r_wr_ptr] <= w_in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
            r_rw    <= 3'd0;
            r_busw  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE, S_RECOVER: begin
                    if (w_pop) begin
                        r_rw    <= r_rd[r_rd_ptr];
                        r_busw  <= r_data[r_rd_ptr];
                        r_wr_en <= 1'b1;
                        r_state <= S_WRITE;
                    end else begin
                        r_wr_en <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_RECOVER;
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Walk the occupied entries from the head; the in-flight write counts too
    always_comb begin
        w_mask = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_count) begin
                w_mask[r_rd[r_rd_ptr + AW'(i)]] = 1'b1;
            end
        end
        if (r_state != S_IDLE) begin
            w_mask[r_rw] = 1'b1;
        end
    end

    assign pending_mask     = w_mask;
    assign queue_count      = r_count;
    assign sig_enable_write = r_wr_en;
    assign RW               = r_rw;
    assign BusW             = r_busw;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Purpose  : Directed self-checking bench for writeback_unit (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_writeback_unit;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_result;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [2:0]  RW;
    logic [15:0] BusW;
    logic        sig_enable_write;
    logic [7:0]  pending_mask;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.DEPTH(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_result       (alu_result),
        .alu_ready        (alu_ready),
        .mem_valid        (mem_valid),
        .mem_rd           (mem_rd),
        .mem_data         (mem_data),
        .mem_ready        (mem_ready),
        .RW               (RW),
        .BusW             (BusW),
        .sig_enable_write (sig_enable_write),
        .pending_mask     (pending_mask),
        .queue_count      (queue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer_alu(input logic [2:0] rd, input logic [15:0] data);
        alu_valid  = 1'b1;
        alu_rd     = rd;
        alu_result = data;
    endtask

    int          k, nw, peak, full_seen, dbl, highs;
    logic        prev, acc;
    int          cyc_w [8];

    initial begin
        reset = 1'b0;
        alu_valid = 1'b0; alu_rd = 3'd0; alu_result = 16'd0;
        mem_valid = 1'b0; mem_rd = 3'd0; mem_data = 16'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_we",    32'(sig_enable_write), 32'd0);
        check("rst_rw",    32'(RW),               32'd0);
        check("rst_busw",  32'(BusW),             32'd0);
        check("rst_mask",  32'(pending_mask),     32'd0);
        check("rst_count", 32'(queue_count),      32'd0);
        check("rst_aready",32'(alu_ready),        32'd0);
        check("rst_mready",32'(mem_ready),        32'd0);

        reset = 1'b1;
        #1;
        check("rel_aready_pre", 32'(alu_ready), 32'd0);
        step();
        check("rel_aready", 32'(alu_ready), 32'd1);
        check("rel_mready", 32'(mem_ready), 32'd1);

        // Single ALU write to R3
        offer_alu(3'd3, 16'h1234);
        step();
        alu_valid = 1'b0;
        check("s1_count", 32'(queue_count), 32'd1);
        check("s1_mask",  32'(pending_mask), 32'h08);
        check("s1_we0",   32'(sig_enable_write), 32'd0);
        step();
        check("s1_we1",   32'(sig_enable_write), 32'd1);
        check("s1_rw",    32'(RW), 32'd3);
        check("s1_busw",  32'(BusW), 32'h1234);
        check("s1_mask_w",32'(pending_mask), 32'h08);
        step();
        check("s1_we_rec",32'(sig_enable_write), 32'd0);
        check("s1_rw_rec",32'(RW), 32'd3);
        check("s1_mask_r",32'(pending_mask), 32'h08);
        step();
        check("s1_mask_i",32'(pending_mask), 32'h00);
        check("s1_we_i",  32'(sig_enable_write), 32'd0);

        // Write to R0 is accepted and discarded
        offer_alu(3'd0, 16'hFFFF);
        #1;
        check("r0_aready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        check("r0_count", 32'(queue_count), 32'd0);
        check("r0_mask",  32'(pending_mask), 32'd0);
        step();
        check("r0_we",    32'(sig_enable_write), 32'd0);

        // Simultaneous offers: mem wins, ALU follows next edge
        mem_valid = 1'b1; mem_rd = 3'd2; mem_data = 16'hAAAA;
        offer_alu(3'd5, 16'h5555);
        #1;
        check("arb_mready", 32'(mem_ready), 32'd1);
        check("arb_aready", 32'(alu_ready), 32'd0);
        step();
        mem_valid = 1'b0;
        #1;
        check("arb_count1", 32'(queue_count), 32'd1);
        check("arb_aready2",32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0;
        check("arb_we1",   32'(sig_enable_write), 32'd1);
        check("arb_rw1",   32'(RW), 32'd2);
        check("arb_busw1", 32'(BusW), 32'hAAAA);
        check("arb_mask1", 32'(pending_mask), 32'h24);
        step();
        check("arb_we_r",  32'(sig_enable_write), 32'd0);
        step();
        check("arb_we2",   32'(sig_enable_write), 32'd1);
        check("arb_rw2",   32'(RW), 32'd5);
        check("arb_busw2", 32'(BusW), 32'h5555);
        check("arb_mask2", 32'(pending_mask), 32'h20);
        step();
        step();
        check("arb_mask_i",32'(pending_mask), 32'h00);

        // Same register queued twice keeps its bit until the second write retires
        offer_alu(3'd4, 16'h0041);
        step();
        offer_alu(3'd4, 16'h0042);
        step();
        alu_valid = 1'b0;
        check("dup_busw1", 32'(BusW), 32'h0041);
        step();
        step();
        check("dup_busw2", 32'(BusW), 32'h0042);
        check("dup_mask_w",32'(pending_mask), 32'h10);
        step();
        check("dup_mask_r",32'(pending_mask), 32'h10);
        step();
        check("dup_mask_i",32'(pending_mask), 32'h00);

        // Sustained ALU stream of 8 writes into a 4-entry queue
        k = 0; nw = 0; peak = 0; full_seen = 0; dbl = 0; prev = 1'b0;
        offer_alu(3'd1, 16'hC000);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            acc = alu_valid && alu_ready;
            step();
            if (acc) k++;
            if (k < 8) offer_alu(3'((k % 7) + 1), 16'hC000 + 16'(k));
            else alu_valid = 1'b0;
            #1;
            if (alu_valid && !alu_ready) full_seen = 1;
            if (int'(queue_count) > peak) peak = int'(queue_count);
            if (sig_enable_write) begin
                if (nw < 8) begin
                    check($sformatf("str_rw%0d", nw),   32'(RW),   32'((nw % 7) + 1));
                    check($sformatf("str_busw%0d", nw), 32'(BusW), 32'(16'hC000 + 16'(nw)));
                    cyc_w[nw] = cyc;
                end
                nw++;
                if (prev) dbl++;
            end
            prev = sig_enable_write;
        end
        check("str_writes", 32'(nw), 32'd8);
        check("str_peak",   32'(peak), 32'd4);
        check("str_full",   32'(full_seen), 32'd1);
        check("str_double", 32'(dbl), 32'd0);
        check("str_first",  32'(cyc_w[0]), 32'd2);
        for (int j = 1; j < 8; j++) begin
            check($sformatf("str_gap%0d", j), 32'(cyc_w[j] - cyc_w[j-1]), 32'd2);
        end
        check("str_count_end", 32'(queue_count), 32'd0);
        check("str_mask_end",  32'(pending_mask), 32'd0);

        // Reset asserted mid-WRITE with two entries still queued
        offer_alu(3'd1, 16'h00A1); step();
        offer_alu(3'd2, 16'h00A2); step();
        offer_alu(3'd3, 16'h00A3); step();
        offer_alu(3'd4, 16'h00A4); step();
        alu_valid = 1'b0;
        check("mid_we_pre",    32'(sig_enable_write), 32'd1);
        check("mid_count_pre", 32'(queue_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_we",    32'(sig_enable_write), 32'd0);
        check("mid_count", 32'(queue_count), 32'd0);
        check("mid_mask",  32'(pending_mask), 32'd0);
        check("mid_rw",    32'(RW), 32'd0);
        check("mid_aready",32'(alu_ready), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        highs = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (sig_enable_write) highs++;
        end
        check("post_highs", 32'(highs), 32'd0);
        check("post_count", 32'(queue_count), 32'd0);
        offer_alu(3'd6, 16'h6666);
        step();
        alu_valid = 1'b0;
        step();
        check("post_we",   32'(sig_enable_write), 32'd1);
        check("post_rw",   32'(RW), 32'd6);
        check("post_busw", 32'(BusW), 32'h6666);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
